// File: rtl/barrier_field_pkg.sv
// Shared types and constants for the barrier field: FSM states, cell geometry,
// the barrier shape mask and the health-to-intensity table.
package barrier_field_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_RESTORE = 2'd2
    } state_e;

    localparam int CELL_SHIFT = 2;
    localparam int CELL_ROWS  = 8;
    localparam int CELL_COLS  = 10;
    localparam int CELLS      = CELL_ROWS * CELL_COLS;
    localparam int BARRIER_H  = 32;
    localparam int BARRIER_W  = 40;

    // MSB of each row is cell column 0
    localparam logic [9:0] SHAPE_MASK [CELL_ROWS] = '{
        10'b0111111110,
        10'b1111111111,
        10'b1111111111,
        10'b1111111111,
        10'b1111001111,
        10'b1110000111,
        10'b1100000011,
        10'b1100000011
    };

    localparam logic [3:0] INTENSITY [4] = '{4'h0, 4'h5, 4'hA, 4'hF};

    function automatic logic mask_on(input logic [2:0] row, input logic [3:0] col);
        logic [9:0] bits;
        bits = SHAPE_MASK[row];
        if (col > 4'd9) return 1'b0;
        return bits[4'd9 - col];
    endfunction

    function automatic logic [6:0] cell_index(input logic [2:0] row, input logic [3:0] col);
        return 7'(row) * 7'(CELL_COLS) + 7'(col);
    endfunction

endpackage

// File: rtl/barrier_field_if.sv
// Shot-probe handshake between the game logic (master) and the barrier field (slave).
interface barrier_field_if;
    logic        hit_valid;
    logic [11:0] hit_row;
    logic [11:0] hit_col;
    logic        hit_ready;
    logic        hit_ack;
    logic        hit_taken;

    modport master (output hit_valid, hit_row, hit_col,
                    input  hit_ready, hit_ack, hit_taken);
    modport slave  (input  hit_valid, hit_row, hit_col,
                    output hit_ready, hit_ack, hit_taken);
endinterface

// File: rtl/barrier_field_locate.sv
// Maps a screen coordinate to the barrier it falls in and the 4x4-pixel cell within it.
module barrier_locate
    import barrier_field_pkg::*;
#(
    parameter int NUM_BARRIERS = 4,
    parameter int BARRIER_ROW  = 380,
    parameter int FIRST_COL    = 120,
    parameter int PITCH        = 120,
    parameter int IDX_W        = 2
) (
    input  logic [11:0]      row_i,
    input  logic [11:0]      col_i,
    output logic             in_barrier_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [2:0]       cell_row_o,
    output logic [3:0]       cell_col_o
);

    logic row_hit;

    always_comb begin
        in_barrier_o = 1'b0;
        idx_o        = '0;
        cell_col_o   = '0;
        row_hit      = (row_i > 12'(BARRIER_ROW)) && (row_i <= 12'(BARRIER_ROW + BARRIER_H));
        cell_row_o   = 3'((row_i - 12'(BARRIER_ROW + 1)) >> CELL_SHIFT);
        // Pitch is at least the barrier width, so at most one column window matches
        for (int k = 0; k < NUM_BARRIERS; k++) begin
            if ((col_i > 12'(FIRST_COL + k * PITCH)) &&
                (col_i <= 12'(FIRST_COL + k * PITCH + BARRIER_W))) begin
                in_barrier_o = row_hit;
                idx_o        = IDX_W'(k);
                cell_col_o   = 4'((col_i - 12'(FIRST_COL + k * PITCH + 1)) >> CELL_SHIFT);
            end
        end
    end

endmodule

// File: rtl/barrier_field.sv
// Destructible barrier field: renders the health map and serves shot probes and restores.
// state      | meaning
// ST_IDLE    | ready for a probe unless a restore is pending or arriving
// ST_CHECK   | probe registered; ack it and decrement the struck cell if live
// ST_RESTORE | rebuild one barrier per cycle, counter 0..NUM_BARRIERS-1
module barrier_field
    import barrier_field_pkg::*;
#(
    parameter int NUM_BARRIERS = 4,
    parameter int BARRIER_ROW  = 380,
    parameter int FIRST_COL    = 120,
    parameter int PITCH        = 120
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             pixel_row,
    input  logic [11:0]             pixel_column,
    input  logic                    restore,
    output logic                    busy,
    output logic [3:0]              barrier_output,
    output logic [NUM_BARRIERS-1:0] barrier_active,
    barrier_field_if.slave          hit
);

    localparam int IDX_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARRIERS - 1);

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [11:0]             probe_row_q, probe_col_q;
    logic [2*CELLS-1:0]      health_q [NUM_BARRIERS];
    logic [3:0]              out_q;
    logic [NUM_BARRIERS-1:0] active_q, active_d;

    logic             r_in, p_in;
    logic [IDX_W-1:0] r_idx, p_idx;
    logic [2:0]       r_crow, p_crow;
    logic [3:0]       r_ccol, p_ccol;
    logic [6:0]       r_cell, p_cell;
    logic [1:0]       r_health, p_health;
    logic             r_mask, p_mask, p_live;

    barrier_locate #(
        .NUM_BARRIERS(NUM_BARRIERS), .BARRIER_ROW(BARRIER_ROW),
        .FIRST_COL(FIRST_COL), .PITCH(PITCH), .IDX_W(IDX_W)
    ) u_locate_render (
        .row_i(pixel_row), .col_i(pixel_column), .in_barrier_o(r_in),
        .idx_o(r_idx), .cell_row_o(r_crow), .cell_col_o(r_ccol)
    );

    barrier_locate #(
        .NUM_BARRIERS(NUM_BARRIERS), .BARRIER_ROW(BARRIER_ROW),
        .FIRST_COL(FIRST_COL), .PITCH(PITCH), .IDX_W(IDX_W)
    ) u_locate_probe (
        .row_i(probe_row_q), .col_i(probe_col_q), .in_barrier_o(p_in),
        .idx_o(p_idx), .cell_row_o(p_crow), .cell_col_o(p_ccol)
    );

    assign r_cell   = cell_index(r_crow, r_ccol);
    assign p_cell   = cell_index(p_crow, p_ccol);
    assign r_health = health_q[r_idx][{r_cell, 1'b0} +: 2];
    assign p_health = health_q[p_idx][{p_cell, 1'b0} +: 2];
    assign r_mask   = mask_on(r_crow, r_ccol);
    assign p_mask   = mask_on(p_crow, p_ccol);
    assign p_live   = p_in && p_mask && (p_health != 2'd0);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        cnt_d         = cnt_q;
        hit.hit_ready = 1'b0;
        hit.hit_ack   = 1'b0;
        hit.hit_taken = 1'b0;
        busy          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pending_d     = 1'b0;
                hit.hit_ready = !pending_q && !restore;
                if (pending_q || restore) begin
                    state_d = ST_RESTORE;
                    cnt_d   = '0;
                end else if (hit.hit_valid) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                hit.hit_ack   = 1'b1;
                hit.hit_taken = p_live;
                pending_d     = pending_q || restore;
                state_d       = ST_IDLE;
            end
            ST_RESTORE: begin
                busy = 1'b1;
                if (restore) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b0;
            cnt_q       <= '0;
            probe_row_q <= '0;
            probe_col_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            if (hit.hit_valid && hit.hit_ready) begin
                probe_row_q <= hit.hit_row;
                probe_col_q <= hit.hit_col;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_BARRIERS; k++) health_q[k] <= '1;
        end else if (state_q == ST_CHECK && p_live) begin
            health_q[p_idx][{p_cell, 1'b0} +: 2] <= p_health - 2'd1;
        end else if (state_q == ST_RESTORE) begin
            health_q[cnt_q] <= '1;
        end
    end

    always_comb begin
        active_d = '0;
        for (int k = 0; k < NUM_BARRIERS; k++) active_d[k] = r_in && (r_idx == IDX_W'(k));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q    <= 4'h0;
            active_q <= '0;
        end else begin
            out_q    <= (r_in && r_mask) ? INTENSITY[r_health] : 4'h0;
            active_q <= active_d;
        end
    end

    assign barrier_output = out_q;
    assign barrier_active = active_q;

endmodule
